// File: rtl/bus_pkg.sv
// Shared definitions for the 8051 write scheduler: page defaults, FSM encodings,
// queue entry layout and the status byte layout.
package bus_pkg;

    localparam logic [7:0] FILT_PAGE_DEF  = 8'h00;
    localparam logic [7:0] TIMER_PAGE_DEF = 8'h01;

    localparam int ENTRY_W = 24;

    localparam int ST_OVF  = 7;
    localparam int ST_BAD  = 6;
    localparam int ST_BUSY = 5;

    typedef enum logic {
        B_IDLE,
        B_ADDR
    } bus_state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_ISSUE
    } disp_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_entry_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic bad,
                                               input logic busy, input logic [3:0] cnt);
        logic [7:0] s;
        s          = '0;
        s[ST_OVF]  = ovf;
        s[ST_BAD]  = bad;
        s[ST_BUSY] = busy;
        s[3:0]     = cnt;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointers one bit wider than the index.
// Push+pop on an empty FIFO passes the word straight through and leaves the count unchanged.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             bypass;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign bypass  = push && pop && empty;
    assign do_pop  = pop && !empty;
    assign do_push = push && !bypass && (!full || do_pop);
    assign dout    = empty ? din : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_wr_sched.sv
// 8051 control-port front end: synchronises the bus strobes, queues CPU writes
// and dispatches each one as a single-cycle strobe to the filter or timer page.
module bus_wr_sched
    import bus_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] FILT_PAGE   = FILT_PAGE_DEF,
    parameter logic [7:0] TIMER_PAGE  = TIMER_PAGE_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        ale,
    input  logic [7:0]  abus,
    input  logic [7:0]  dbus,
    input  logic        w_n,
    input  logic        r_n,
    input  logic        filt_ready,
    input  logic        timer_ready,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        filt_we_n,
    output logic        timer_we_n,
    output logic [7:0]  rd_data,
    output logic        rd_oe,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] cs_sync, ale_sync, w_sync, r_sync;
    logic                   cs_prev, ale_prev, w_prev, r_prev;
    logic [7:0]             abus_pipe [SYNC_STAGES];
    logic [7:0]             dbus_pipe [SYNC_STAGES];

    // Synchroniser stages; bus bytes ride an equal-length pipe so they line up with the edges
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '1;
            ale_sync <= '0;
            w_sync   <= '1;
            r_sync   <= '1;
            cs_prev  <= 1'b1;
            ale_prev <= 1'b0;
            w_prev   <= 1'b1;
            r_prev   <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            ale_sync <= {ale_sync[SYNC_STAGES-2:0], ale};
            w_sync   <= {w_sync[SYNC_STAGES-2:0], w_n};
            r_sync   <= {r_sync[SYNC_STAGES-2:0], r_n};
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            ale_prev <= ale_sync[SYNC_STAGES-1];
            w_prev   <= w_sync[SYNC_STAGES-1];
            r_prev   <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clock) begin
        abus_pipe[0] <= abus;
        dbus_pipe[0] <= dbus;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            abus_pipe[i] <= abus_pipe[i-1];
            dbus_pipe[i] <= dbus_pipe[i-1];
        end
    end

    logic       cs_s, cs_low;
    logic       ale_fall, w_rise, r_fall, r_rise;
    logic [7:0] abus_s, dbus_s;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign cs_low   = !cs_s;
    assign ale_fall = ale_prev && !ale_sync[SYNC_STAGES-1];
    assign w_rise   = w_sync[SYNC_STAGES-1] && !w_prev;
    assign r_fall   = r_prev && !r_sync[SYNC_STAGES-1];
    assign r_rise   = r_sync[SYNC_STAGES-1] && !r_prev;
    assign abus_s   = abus_pipe[SYNC_STAGES-1];
    assign dbus_s   = dbus_pipe[SYNC_STAGES-1];

    bus_state_t  bstate;
    logic [15:0] addr_q;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_dout;

    assign push = (bstate == B_ADDR) && w_rise && cs_low;

    // Bus FSM: address phase tracking
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bstate <= B_IDLE;
            addr_q <= '0;
        end else begin
            case (bstate)
                B_IDLE: begin
                    if (ale_fall && cs_low) begin
                        addr_q <= {abus_s, dbus_s};
                        bstate <= B_ADDR;
                    end
                end
                B_ADDR: begin
                    if (cs_s) begin
                        bstate <= B_IDLE;
                    end else if (ale_fall) begin
                        addr_q <= {abus_s, dbus_s};
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({addr_q, dbus_s}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    disp_state_t dstate;
    wr_entry_t   head;
    logic        is_filt, is_timer, known, tgt_ready, disp_bad;

    assign head      = wr_entry_t'(fifo_dout);
    assign is_filt   = (head.addr[15:8] == FILT_PAGE);
    assign is_timer  = !is_filt && (head.addr[15:8] == TIMER_PAGE);
    assign known     = is_filt || is_timer;
    assign tgt_ready = (is_filt && filt_ready) || (is_timer && timer_ready);
    assign disp_bad  = (dstate == D_IDLE) && !fifo_empty && !known;

    always_comb begin
        pop = 1'b0;
        case (dstate)
            D_IDLE:  pop = !fifo_empty && (!known || tgt_ready);
            D_WAIT:  pop = tgt_ready;
            default: pop = 1'b0;
        endcase
    end

    // Dispatch FSM: strobe launches from IDLE/WAIT, ISSUE is the strobe cycle
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dstate     <= D_IDLE;
            wr_addr    <= '0;
            wr_data    <= '0;
            filt_we_n  <= 1'b1;
            timer_we_n <= 1'b1;
        end else begin
            filt_we_n  <= 1'b1;
            timer_we_n <= 1'b1;
            case (dstate)
                D_IDLE: begin
                    if (!fifo_empty) begin
                        wr_addr <= head.addr;
                        wr_data <= head.data;
                        if (!known) begin
                            dstate <= D_ISSUE;
                        end else if (tgt_ready) begin
                            filt_we_n  <= !is_filt;
                            timer_we_n <= !is_timer;
                            dstate     <= D_ISSUE;
                        end else begin
                            dstate <= D_WAIT;
                        end
                    end
                end
                D_WAIT: begin
                    if (tgt_ready) begin
                        filt_we_n  <= !is_filt;
                        timer_we_n <= !is_timer;
                        dstate     <= D_ISSUE;
                    end
                end
                D_ISSUE: dstate <= D_IDLE;
                default: dstate <= D_IDLE;
            endcase
        end
    end

    assign busy = !fifo_empty || (dstate != D_IDLE);

    logic ovf, bad, ovf_set, bad_set, rd_start, rd_end;

    assign ovf_set  = push && fifo_full && !pop;
    // A write colliding with a read edge wins; the read edge is only flagged
    assign bad_set  = (w_rise && cs_low && (bstate == B_IDLE))
                   || (w_rise && (r_fall || r_rise))
                   || disp_bad;
    assign rd_start = r_fall && cs_low && !w_rise;
    assign rd_end   = r_rise && rd_oe;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            bad     <= 1'b0;
            rd_oe   <= 1'b0;
            rd_data <= '0;
        end else begin
            if (rd_end) begin
                ovf   <= ovf_set;
                bad   <= bad_set;
                rd_oe <= 1'b0;
            end else begin
                ovf <= ovf || ovf_set;
                bad <= bad || bad_set;
                if (rd_start) begin
                    rd_oe   <= 1'b1;
                    rd_data <= status_byte(ovf, bad, busy, 4'(fifo_count));
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_wr_sched.sv
// Directed bench for bus_wr_sched: drives 8051-style bus cycles and checks
// dispatched strobes, status reads and reset behaviour against hand-computed values.
module tb_bus_wr_sched;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        cs_n, ale, w_n, r_n;
    logic [7:0]  abus, dbus;
    logic        filt_ready, timer_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        filt_we_n, timer_we_n;
    logic [7:0]  rd_data;
    logic        rd_oe;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    int          filt_lo, timer_lo, filt_pulses, timer_pulses;
    logic [23:0] cap_q [$];
    logic        filt_prev = 1'b1;
    logic        timer_prev = 1'b1;

    always #5 clock = ~clock;

    bus_wr_sched dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .ale         (ale),
        .abus        (abus),
        .dbus        (dbus),
        .w_n         (w_n),
        .r_n         (r_n),
        .filt_ready  (filt_ready),
        .timer_ready (timer_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .filt_we_n   (filt_we_n),
        .timer_we_n  (timer_we_n),
        .rd_data     (rd_data),
        .rd_oe       (rd_oe),
        .busy        (busy)
    );

    always @(negedge clock) begin
        if (!filt_we_n) begin
            filt_lo++;
            cap_q.push_back({wr_addr, wr_data});
        end
        if (!timer_we_n) begin
            timer_lo++;
            cap_q.push_back({wr_addr, wr_data});
        end
        if (filt_prev && !filt_we_n)   filt_pulses++;
        if (timer_prev && !timer_we_n) timer_pulses++;
        filt_prev  = filt_we_n;
        timer_prev = timer_we_n;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_mon();
        filt_lo = 0;
        timer_lo = 0;
        filt_pulses = 0;
        timer_pulses = 0;
        cap_q.delete();
    endtask

    task automatic bus_ale(input logic [15:0] a);
        cs_n = 1'b0;
        cyc(2);
        abus = a[15:8];
        dbus = a[7:0];
        ale  = 1'b1;
        cyc(3);
        ale  = 1'b0;
        cyc(4);
    endtask

    task automatic bus_wr(input logic [7:0] d);
        dbus = d;
        cyc(1);
        w_n = 1'b0;
        cyc(3);
        w_n = 1'b1;
        cyc(4);
    endtask

    task automatic bus_rd(input string tag, input logic [7:0] exp);
        cs_n = 1'b0;
        cyc(2);
        r_n = 1'b0;
        cyc(4);
        chk_eq({tag, "_oe"}, 32'(rd_oe), 32'd1);
        chk_eq({tag, "_data"}, 32'(rd_data), 32'(exp));
        r_n = 1'b1;
        cyc(4);
        chk_eq({tag, "_oe_off"}, 32'(rd_oe), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n = 1'b1; ale = 1'b0; w_n = 1'b1; r_n = 1'b1;
        abus = '0; dbus = '0;
        filt_ready = 1'b0; timer_ready = 1'b0;
        clear_mon();
        cyc(3);
        chk_eq("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk_eq("rst_wr_data", 32'(wr_data), 32'h0);
        chk_eq("rst_filt_we_n", 32'(filt_we_n), 32'h1);
        chk_eq("rst_timer_we_n", 32'(timer_we_n), 32'h1);
        chk_eq("rst_rd_data", 32'(rd_data), 32'h0);
        chk_eq("rst_rd_oe", 32'(rd_oe), 32'h0);
        chk_eq("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc(3);

        // 1: simple filter write
        clear_mon();
        filt_ready = 1'b1;
        bus_ale(16'h0005);
        bus_wr(8'hA3);
        cs_n = 1'b1;
        cyc(10);
        chk_eq("t1_filt_lo", 32'(filt_lo), 32'd1);
        chk_eq("t1_filt_pulses", 32'(filt_pulses), 32'd1);
        chk_eq("t1_timer_lo", 32'(timer_lo), 32'd0);
        chk_eq("t1_cap", 32'(cap_q.size() > 0 ? cap_q[0] : 24'h0), 32'h0005A3);
        chk_eq("t1_busy", 32'(busy), 32'd0);

        // 2: timer write held off by timer_ready
        clear_mon();
        timer_ready = 1'b0;
        bus_ale(16'h0102);
        bus_wr(8'h17);
        cs_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk_eq("t2_busy_wait", 32'(busy), 32'd1);
            cyc(1);
        end
        chk_eq("t2_no_strobe", 32'(timer_lo), 32'd0);
        timer_ready = 1'b1;
        cyc(6);
        chk_eq("t2_timer_lo", 32'(timer_lo), 32'd1);
        chk_eq("t2_timer_pulses", 32'(timer_pulses), 32'd1);
        chk_eq("t2_filt_lo", 32'(filt_lo), 32'd0);
        chk_eq("t2_cap", 32'(cap_q.size() > 0 ? cap_q[0] : 24'h0), 32'h010217);
        chk_eq("t2_busy_end", 32'(busy), 32'd0);

        // 3: overflow with FIFO_DEPTH+1 writes
        clear_mon();
        filt_ready = 1'b0;
        bus_ale(16'h0010);
        for (int i = 1; i <= 5; i++) bus_wr(8'(i));
        bus_rd("t3_status", 8'hA4);
        chk_eq("t3_held", 32'(filt_lo), 32'd0);
        cs_n = 1'b1;
        filt_ready = 1'b1;
        cyc(20);
        chk_eq("t3_filt_lo", 32'(filt_lo), 32'd4);
        chk_eq("t3_filt_pulses", 32'(filt_pulses), 32'd4);
        chk_eq("t3_ncap", 32'(cap_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap_q.size(); i++)
            chk_eq("t3_order", 32'(cap_q[i]), 32'({16'h0010, 8'(i + 1)}));

        // 4: unmapped page
        clear_mon();
        bus_ale(16'h7F00);
        bus_wr(8'h55);
        cs_n = 1'b1;
        cyc(10);
        chk_eq("t4_filt_lo", 32'(filt_lo), 32'd0);
        chk_eq("t4_timer_lo", 32'(timer_lo), 32'd0);
        chk_eq("t4_busy", 32'(busy), 32'd0);
        bus_rd("t4_rd1", 8'h40);
        bus_rd("t4_rd2", 8'h00);
        cs_n = 1'b1;
        cyc(4);

        // 5: write without an address phase
        clear_mon();
        cs_n = 1'b0;
        cyc(3);
        bus_wr(8'h66);
        cs_n = 1'b1;
        cyc(8);
        chk_eq("t5_busy", 32'(busy), 32'd0);
        chk_eq("t5_no_strobe", 32'(filt_lo + timer_lo), 32'd0);
        bus_rd("t5_status", 8'h40);
        cs_n = 1'b1;
        cyc(4);

        // 6: reset while a strobe is pending
        clear_mon();
        filt_ready = 1'b0;
        bus_ale(16'h0000);
        bus_wr(8'h99);
        cs_n = 1'b1;
        cyc(3);
        chk_eq("t6_pending_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_busy", 32'(busy), 32'd0);
        chk_eq("t6_rst_filt_we_n", 32'(filt_we_n), 32'd1);
        chk_eq("t6_rst_wr_addr", 32'(wr_addr), 32'h0);
        chk_eq("t6_rst_wr_data", 32'(wr_data), 32'h0);
        chk_eq("t6_rst_rd_oe", 32'(rd_oe), 32'd0);
        filt_ready = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        chk_eq("t6_no_strobe", 32'(filt_lo), 32'd0);
        chk_eq("t6_busy_after", 32'(busy), 32'd0);
        bus_rd("t6_status", 8'h00);
        cs_n = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
